// File: rtl/diff_stream_ctrl.sv
// diff_stream_ctrl: framed mod-4 differential encoder with valid/ready handshakes and a registered output stage.
// Define DIFF_STREAM_CSUM_EN to add out_csum, a running mod-4 sum of encoded digits per frame.
module diff_word #(
   parameter int N = 8
) (
   input  logic [2*N-1:0] word_i,
   output logic [2*N-1:0] diff_o
);
   for (genvar g = 0; g < N - 1; g++) begin : g_dig
      assign diff_o[2*g+:2] = word_i[2*g+:2] - word_i[2*g+2+:2];
   end
   assign diff_o[2*N-1-:2] = word_i[2*N-1-:2];
endmodule

module diff_stream_ctrl #(
   parameter int N     = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2*N-1:0]   in_word,
   input  logic             in_sof,
   input  logic             in_eof,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*N-1:0]   out_word,
   output logic             out_sof,
   output logic             out_eof,
   output logic [CNT_W-1:0] out_idx,
`ifdef DIFF_STREAM_CSUM_EN
   output logic [1:0]       out_csum,
`endif
   output logic             frame_err
);
   typedef enum logic {IDLE, FRAME} state_e;
   state_e           state_q, state_d;
   logic             acc, first, err_d;
   logic [1:0]       carry_q;
   logic [2*N-1:0]   diff, word_d, word_q;
   logic [CNT_W-1:0] idx_d, idx_q;
   logic             valid_q, sof_q, eof_q, err_q;

   diff_word #(.N(N)) u_diff (.word_i(in_word), .diff_o(diff));

   assign in_ready = ~rst & (~valid_q | out_ready);
   assign acc      = in_valid & in_ready;

   always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;

   always_comb state_d = acc ? (in_eof ? IDLE : FRAME) : state_q;

   // A word without sof in IDLE, or with sof inside a frame, both open a fresh frame and flag an error.
   always_comb begin
      first  = (state_q == IDLE) | in_sof;
      err_d  = acc & ((state_q == IDLE) ^ in_sof);
      word_d = {first ? diff[2*N-1-:2] : diff[2*N-1-:2] - carry_q, diff[2*N-3:0]};
      idx_d  = first ? '0 : idx_q + CNT_W'(~&idx_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         word_q  <= '0;
         sof_q   <= 1'b0;
         eof_q   <= 1'b0;
         idx_q   <= '0;
         carry_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (in_ready) valid_q <= in_valid;
         if (acc) begin
            word_q  <= word_d;
            sof_q   <= first;
            eof_q   <= in_eof;
            idx_q   <= idx_d;
            carry_q <= in_word[1:0];
         end
         err_q <= err_d;
      end
   end

`ifdef DIFF_STREAM_CSUM_EN
   logic [1:0] csum_q, csum_d;
   always_comb begin
      csum_d = first ? 2'd0 : csum_q;
      for (int k = 0; k < N; k++) csum_d = csum_d + word_d[2*k+:2];
   end
   always_ff @(posedge clk) begin
      if (rst) csum_q <= '0;
      else if (acc) csum_q <= csum_d;
   end
   assign out_csum = csum_q;
`endif

   assign out_valid = valid_q;
   assign out_word  = word_q;
   assign out_sof   = sof_q;
   assign out_eof   = eof_q;
   assign out_idx   = idx_q;
   assign frame_err = err_q;
endmodule

// File: tb/tb_diff_stream_ctrl.sv
// tb_diff_stream_ctrl: randomized and directed checks of diff_stream_ctrl (N=4, CNT_W=3) against a digit-level model.
module tb_diff_stream_ctrl;
   localparam int N = 4;
   localparam int CNT_W = 3;

   logic             clk = 0, rst = 1;
   logic             in_valid = 0, in_sof = 0, in_eof = 0, out_ready = 1;
   logic [2*N-1:0]   in_word = '0;
   logic             in_ready, out_valid, out_sof, out_eof, frame_err;
   logic [2*N-1:0]   out_word;
   logic [CNT_W-1:0] out_idx;
   logic [1:0]       out_csum;

   diff_stream_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
      .in_sof(in_sof), .in_eof(in_eof),
      .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
      .out_sof(out_sof), .out_eof(out_eof), .out_idx(out_idx),
`ifdef DIFF_STREAM_CSUM_EN
      .out_csum(out_csum),
`endif
      .frame_err(frame_err)
   );
`ifndef DIFF_STREAM_CSUM_EN
   assign out_csum = 2'd0;
`endif

   always #5 clk = ~clk;

   int n_vec = 0, n_bad = 0, n_err = 0, stall = 0;
   bit rnd_rdy = 0;

   typedef struct {
      logic [7:0] w;
      int         idx;
      logic       sof, eof;
      logic [1:0] cs;
   } ent_t;
   ent_t log_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: expected contents of the output stage, computed digit by digit.
   int e_valid = 0, e_word = 0, e_sof = 0, e_eof = 0, e_idx = 0, e_err = 0, e_csum = 0;
   int in_frame = 0, prev = 0;

   always @(negedge clk) begin : mdl
      int m_rdy, acc, first, dig, sum;
      int d[N];
      m_rdy = (!rst && (!e_valid || out_ready)) ? 1 : 0;
      chk("in_ready", 32'(in_ready), 32'(m_rdy));
      chk("out_valid", 32'(out_valid), 32'(e_valid));
      chk("out_word", 32'(out_word), 32'(e_word));
      chk("out_sof", 32'(out_sof), 32'(e_sof));
      chk("out_eof", 32'(out_eof), 32'(e_eof));
      chk("out_idx", 32'(out_idx), 32'(e_idx));
      chk("frame_err", 32'(frame_err), 32'(e_err));
`ifdef DIFF_STREAM_CSUM_EN
      chk("out_csum", 32'(out_csum), 32'(e_csum));
`endif
      if (frame_err && !rst) n_err++;
      if (out_valid && out_ready && !rst) begin
         ent_t en;
         en.w = out_word; en.idx = int'(out_idx); en.sof = out_sof; en.eof = out_eof; en.cs = out_csum;
         log_q.push_back(en);
      end
      acc = (in_valid && m_rdy) ? 1 : 0;
      if (rst) begin
         e_valid = 0; e_word = 0; e_sof = 0; e_eof = 0; e_idx = 0; e_err = 0; e_csum = 0;
         in_frame = 0; prev = 0;
      end else begin
         e_err = 0;
         if (m_rdy) e_valid = in_valid ? 1 : 0;
         if (acc) begin
            first = (!in_frame || in_sof) ? 1 : 0;
            e_err = in_frame ? int'(in_sof) : int'(!in_sof);
            for (int i = 0; i < N; i++) d[i] = int'((in_word >> (2*i)) & 8'h3);
            e_word = 0;
            sum = 0;
            for (int i = 0; i < N; i++) begin
               if (i == N - 1) dig = first ? d[i] : (d[i] - prev + 4) % 4;
               else dig = (d[i] - d[i+1] + 4) % 4;
               e_word += dig << (2*i);
               sum += dig;
            end
            e_csum = ((first ? 0 : e_csum) + sum) % 4;
            e_idx = first ? 0 : (e_idx == 7 ? 7 : e_idx + 1);
            e_sof = first;
            e_eof = int'(in_eof);
            prev = d[0];
            in_frame = in_eof ? 0 : 1;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (stall > 0) begin
         out_ready = 0;
         stall--;
      end else out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
   end

   task automatic put(input logic [7:0] w, input logic s, input logic e);
      int n = 0;
      @(posedge clk); #1;
      in_valid = 1; in_word = w; in_sof = s; in_eof = e;
      @(negedge clk);
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) chk("accept_timeout", 32'(n), 32'(0));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         in_valid = 0;
      end
   endtask

   initial begin
      int e0;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      // Scenario 1: single frame, continuous ready
      log_q.delete();
      put(8'h1B, 1, 0); put(8'hE4, 0, 1); idle(3);
      chk("s1_cnt", 32'(log_q.size()), 2);
      chk("s1_w0", 32'(log_q[0].w), 32'h15);
      chk("s1_i0", 32'(log_q[0].idx), 0);
      chk("s1_w1", 32'(log_q[1].w), 32'h3F);
      chk("s1_i1", 32'(log_q[1].idx), 1);
`ifdef DIFF_STREAM_CSUM_EN
      chk("s1_cs", 32'(log_q[1].cs), 0);
`endif
      // Scenario 2: back-to-back single-word frames
      log_q.delete();
      put(8'h1B, 1, 1); put(8'hE4, 1, 1); idle(3);
      chk("s2_w0", 32'(log_q[0].w), 32'h15);
      chk("s2_w1", 32'(log_q[1].w), 32'hFF);
      // Scenario 3: backpressure on the first output
      log_q.delete();
      put(8'h1B, 1, 0);
      stall = 3;
      put(8'hE4, 0, 1); idle(3);
      chk("s3_cnt", 32'(log_q.size()), 2);
      chk("s3_w0", 32'(log_q[0].w), 32'h15);
      chk("s3_w1", 32'(log_q[1].w), 32'h3F);
      // Scenario 4: protocol errors
      log_q.delete();
      e0 = n_err;
      put(8'h6C, 0, 1); put(8'h1B, 1, 0); put(8'hE4, 1, 1); idle(3);
      chk("s4_w0", 32'(log_q[0].w), 32'h55);
      chk("s4_sof0", 32'(log_q[0].sof), 1);
      chk("s4_w2", 32'(log_q[2].w), 32'hFF);
      chk("s4_i2", 32'(log_q[2].idx), 0);
      chk("s4_errs", 32'(n_err - e0), 2);
`ifdef DIFF_STREAM_CSUM_EN
      chk("s6_cs_6c", 32'(log_q[0].cs), 0);
      log_q.delete();
      put(8'h1B, 1, 1); idle(3);
      chk("s6_cs_1b", 32'(log_q[0].cs), 3);
`endif
      // Scenario 5: reset mid-frame
      put(8'h1B, 1, 0);
      @(posedge clk); #1;
      in_valid = 0; rst = 1;
      @(negedge clk);
      chk("s5_rdy_rst", 32'(in_ready), 0);
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      chk("s5_valid", 32'(out_valid), 0);
      log_q.delete();
      put(8'hE4, 1, 1); idle(3);
      chk("s5_w", 32'(log_q[0].w), 32'hFF);
      // Index saturation with a 3-bit counter
      log_q.delete();
      put(8'h00, 1, 0);
      for (int i = 0; i < 9; i++) put(8'(i * 37), 0, i == 8);
      idle(3);
      chk("sat_idx", 32'(log_q[9].idx), 7);
      chk("sat_idx7", 32'(log_q[7].idx), 7);
      // Random traffic with random backpressure
      rnd_rdy = 1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         put(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      end
      rnd_rdy = 0;
      idle(6);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
